// File: rtl/tdm_demux16.sv
// Receive end of a 16:1 TDM link: assembles one serial bit per valid cycle
// into a parallel word and tracks frame alignment with a HUNT/RECV machine.
module tdm_demux16 #(
  parameter int N_CH  = 16,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             frame_start,
  output logic [N_CH-1:0]  out,
  output logic             frame_valid,
  output logic [SEL_W-1:0] sel,
  output logic             sync_err,
  output logic             locked
);

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_t;

  localparam logic [SEL_W-1:0] SEL_ZERO = '0;
  localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_CH - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SEL_W-1:0]  r_sel;
  logic [SEL_W-1:0]  w_sel_nxt;
  logic [N_CH-1:0]   r_shadow;
  logic [N_CH-1:0]   w_shadow_nxt;
  logic [N_CH-1:0]   r_out;
  logic [N_CH-1:0]   w_out_nxt;
  logic              r_frame_valid;
  logic              w_frame_valid_nxt;
  logic              r_sync_err;
  logic              w_sync_err_nxt;

  // State, channel index, shadow word, published word and strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= HUNT;
      r_sel         <= SEL_ZERO;
      r_shadow      <= '0;
      r_out         <= '0;
      r_frame_valid <= 1'b0;
      r_sync_err    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_sel         <= w_sel_nxt;
      r_shadow      <= w_shadow_nxt;
      r_out         <= w_out_nxt;
      r_frame_valid <= w_frame_valid_nxt;
      r_sync_err    <= w_sync_err_nxt;
    end
  end

  // Next-state and datapath decode; idle cycles only drop the strobes.
  always_comb begin
    w_state_nxt       = r_state;
    w_sel_nxt         = r_sel;
    w_shadow_nxt      = r_shadow;
    w_out_nxt         = r_out;
    w_frame_valid_nxt = 1'b0;
    w_sync_err_nxt    = 1'b0;
    if (in_valid) begin
      case (r_state)
        HUNT: begin
          if (frame_start) begin
            w_shadow_nxt[0] = in_bit;
            w_sel_nxt       = SEL_ONE;
            w_state_nxt     = RECV;
          end else begin
            w_sel_nxt       = SEL_ZERO;
          end
        end
        RECV: begin
          if (frame_start) begin
            // A start mid-frame abandons the partial word and realigns here.
            w_shadow_nxt[0] = in_bit;
            w_sel_nxt       = SEL_ONE;
            w_sync_err_nxt  = (r_sel != SEL_ZERO);
          end else if (r_sel == SEL_ZERO) begin
            w_sync_err_nxt  = 1'b1;
            w_state_nxt     = HUNT;
          end else if (r_sel == SEL_LAST) begin
            w_shadow_nxt[r_sel] = in_bit;
            w_out_nxt           = {in_bit, r_shadow[N_CH-2:0]};
            w_frame_valid_nxt   = 1'b1;
            w_sel_nxt           = SEL_ZERO;
          end else begin
            w_shadow_nxt[r_sel] = in_bit;
            w_sel_nxt           = r_sel + SEL_ONE;
          end
        end
        default: begin
          w_state_nxt = HUNT;
          w_sel_nxt   = SEL_ZERO;
        end
      endcase
    end else begin
      w_sel_nxt = r_sel;
    end
  end

  assign out         = r_out;
  assign frame_valid = r_frame_valid;
  assign sync_err    = r_sync_err;
  assign sel         = r_sel;
  assign locked      = (r_state == RECV);

endmodule

// File: tb/tb_tdm_demux16.sv
// Randomized scoreboard bench for tdm_demux16: a frame-level reference model
// predicts strobes into a queue that an independent negedge monitor drains.
module tb_tdm_demux16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        frame_start = 1'b0;
  logic [15:0] out;
  logic        frame_valid;
  logic [3:0]  sel;
  logic        sync_err;
  logic        locked;

  tdm_demux16 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .frame_start(frame_start), .out(out), .frame_valid(frame_valid),
    .sel(sel), .sync_err(sync_err), .locked(locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [15:0] val;
    int          stamp;
  } ev_t;

  ev_t         exp_q[$];
  bit          m_bits[$];
  bit          m_locked = 1'b0;
  logic [15:0] m_out = 16'h0000;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_sel();
    return m_locked ? 4'(m_bits.size()) : 4'd0;
  endfunction

  // Reference: the frame is the list of bits since the last accepted start.
  task automatic model_step(input logic v, input logic b, input logic fs);
    ev_t e;
    logic [15:0] w;
    if (!v) return;
    e.stamp = cyc;
    e.val = 16'h0000;
    if (fs) begin
      if (m_locked && m_bits.size() != 0) begin
        e.is_err = 1'b1; exp_q.push_back(e);
      end
      m_bits.delete();
      m_bits.push_back(b);
      m_locked = 1'b1;
    end else if (m_locked) begin
      if (m_bits.size() == 0) begin
        e.is_err = 1'b1; exp_q.push_back(e);
        m_locked = 1'b0;
      end else begin
        m_bits.push_back(b);
        if (m_bits.size() == 16) begin
          w = 16'h0000;
          for (int i = 0; i < 16; i++) if (m_bits[i]) w = w | (16'h0001 << i);
          m_out = w;
          e.is_err = 1'b0; e.val = w; exp_q.push_back(e);
          m_bits.delete();
        end
      end
    end
  endtask

  task automatic apply(input logic v, input logic b, input logic fs);
    @(negedge clk);
    chk("sel", 32'(sel), 32'(m_sel()));
    chk("locked", 32'(locked), 32'(m_locked));
    chk("out", 32'(out), 32'(m_out));
    in_valid = v; in_bit = b; frame_start = fs;
    @(posedge clk);
    model_step(v, b, fs);
  endtask

  task automatic send_frame(input logic [15:0] word, input bit gap);
    for (int i = 0; i < 16; i++) begin
      apply(1'b1, word[i], (i == 0));
      if (gap && i < 15) apply(1'b0, 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst out", 32'(out), 32'h0);
    chk("rst sel", 32'(sel), 32'h0);
    chk("rst locked", 32'(locked), 32'h0);
    chk("rst strobes", 32'({frame_valid, sync_err}), 32'h0);
    m_bits.delete(); m_locked = 1'b0; m_out = 16'h0000; exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every strobe must match the oldest prediction from this cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_valid && sync_err) chk("strobe overlap", 32'h1, 32'h0);
      if (frame_valid || sync_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected strobe", 32'({frame_valid, sync_err}), 32'h0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("strobe kind", 32'(sync_err), 32'(e.is_err));
          chk("strobe cycle", 32'(cyc), 32'(e.stamp));
          if (!e.is_err) chk("frame word", 32'(out), 32'(e.val));
        end
      end else if (exp_q.size() != 0 && exp_q[0].stamp <= cyc) begin
        chk("missing strobe", 32'h0, 32'(exp_q[0].is_err ? 2 : 1));
        void'(exp_q.pop_front());
      end
    end
    cyc++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    for (int i = 0; i < 5; i++) apply(1'b0, 1'($urandom), 1'($urandom));
    for (int k = 0; k < 16; k++) send_frame(16'h0001 << k, 1'b0);
    send_frame(16'hA5C3, 1'b1);
    for (int i = 0; i < 7; i++) apply(1'b1, 1'($urandom), (i == 0));
    send_frame(16'h8001, 1'b0);
    send_frame(16'hFFFF, 1'b0);
    apply(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) apply(1'b1, 1'($urandom), 1'b0);
    send_frame(16'h0F0F, 1'b0);
    for (int i = 0; i < 10; i++) apply(1'b1, 1'b1, (i == 0));
    do_reset();
    send_frame(16'h1234, 1'b0);
    for (int i = 0; i < 1500; i++) begin
      logic v, fs;
      v  = ($urandom % 4) != 0;
      fs = (m_bits.size() == 0 && ($urandom % 4) != 0) || (($urandom % 24) == 0);
      apply(v, 1'($urandom), fs);
    end
    apply(1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b0);
    chk("drain", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tdm_demux16.md
Name: tdm_demux16

Overview:
- Time-division 1-to-16 demultiplexer; the receive end of a 16:1 mux link that sends one channel bit per valid cycle, channel 0 first, flagged by frame_start.
- Assembles 16 consecutive valid bits into a parallel word, publishes it with a one-cycle strobe, and tracks frame alignment with a small state machine.
- Sits after the 16x1 mux path so the same one-hot channel patterns can be recovered in parallel.

Parameters:
- N_CH, 16, channels per frame; fixed at 16 for this block.
- SEL_W, 4, channel-index width, equal to log2(N_CH).

Ports:
- clk  input  1  system clock, all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_bit and frame_start are valid this cycle
- in_bit  input  1  serial channel bit from the mux link
- frame_start  input  1  qualifies the current valid bit as channel 0
- out  output  16  last complete frame; bit i = channel i
- frame_valid  output  1  one-cycle strobe: out has just been updated
- sel  output  SEL_W  channel index the next valid bit will be written to
- sync_err  output  1  one-cycle strobe on an alignment violation
- locked  output  1  high while in state RECV

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high, port rst.
- While rst is high, all of the following hold:
  - out = 16'h0000; frame_valid = 0; sync_err = 0; locked = 0; sel = 0.
  - Internal shadow register = 0; state = HUNT.
- Reset asserted mid-frame discards the partial frame immediately. It does not wait for a clock edge.
- Cycles with in_valid = 0 change nothing except clearing the frame_valid and sync_err strobes. sel holds, and in_bit and frame_start are ignored.
- State HUNT (locked = 0):
  - in_valid & frame_start: shadow[0] <= in_bit; sel <= 1; go to RECV.
  - in_valid & !frame_start: bit discarded; sel stays 0; no sync_err.
- State RECV (locked = 1), on in_valid:
  - sel != 0 and !frame_start: shadow[sel] <= in_bit; sel <= sel + 1. The 4-bit value wraps 15 -> 0.
  - sel == 15 and !frame_start: the frame completes on the same edge.
    - out <= {in_bit, shadow[14:0]}.
    - frame_valid = 1 for exactly the next cycle.
    - sel <= 0; stay in RECV.
  - sel == 0 and frame_start: starts the next frame. shadow[0] <= in_bit; sel <= 1; stay in RECV. Back-to-back frames need no idle cycles.
  - sel != 0 and frame_start (early restart):
    - sync_err = 1 for the next cycle.
    - Partial frame discarded; out is unchanged and frame_valid is not asserted.
    - The current bit is treated as channel 0: shadow[0] <= in_bit; sel <= 1; stay in RECV.
  - sel == 0 and !frame_start (missing start):
    - sync_err = 1 for the next cycle.
    - Bit discarded; sel = 0; go to HUNT.
- Shadow bits are not cleared between frames. Every bit of out is overwritten on completion, so stale shadow data never reaches out.
- Latency: out reflects a frame from the edge that accepts the channel-15 bit. frame_valid is high in the cycle following that edge.
- out holds its value until the next completed frame or reset.
- frame_valid and sync_err are never high in the same cycle.

Test Plan:
- Reset and idle:
  - Assert rst asynchronously between edges -> all outputs 0 immediately.
  - Release rst and drive 5 cycles of in_valid = 0 -> state unchanged, locked = 0.
- One-hot frames:
  - For each k = 0..15, send a frame whose only set bit is channel k, with frame_start on channel 0 and in_valid continuous.
  - Each frame -> out = 16'h0001 << k, one frame_valid pulse per frame, no sync_err.
  - Frames run back-to-back -> locked stays 1 throughout.
- Gapped input:
  - Send frame 16'hA5C3 with in_valid low every other cycle -> out = 16'hA5C3 after 31 cycles, with sel holding during the gaps.
- Early restart:
  - Send 7 bits of a frame, then frame_start with new frame 16'h8001 -> sync_err pulse.
  - No frame_valid for the partial frame; out still holds its previous value.
  - Then out = 16'h8001 after 16 more valid bits.
- Missing start:
  - After a good frame 16'hFFFF, send a valid bit with frame_start = 0 -> sync_err pulse, locked = 0.
  - Further bits are ignored until frame_start; the next frame 16'h0F0F -> out = 16'h0F0F.
- Reset mid-frame:
  - Send 10 bits, then pulse rst -> out = 0, sel = 0, locked = 0.
  - Next full frame 16'h1234 -> out = 16'h1234, with no stale bits from before the reset.
